// File: rtl/mem_share_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_share_rr_arbiter_if
// Bundles the batch request inputs and the grant / write-back outputs of one
// shared column-bank group.
//   slave  : arbiter side (requests in, grants / write-backs out)
//   master : requester / environment side (mirror of slave)
// Signals:
//   rqst_flag_i      per-requester request flags
//   rqst_addr_i      packed column addresses, requester r at [r*W +: W]
//   batch_start_i    batch start pulse
//   c2v_base_addr_i  write-back base address
//   grant_o          one-hot grant (zero when idle)
//   shared_ren_o     shared-memory read enable
//   shared_raddr_o   address of the granted requester
//   wb_en_o          C2V write-back strobe
//   wb_idx_o         requester index of the write-back
//   wb_waddr_o       write-back address (base + index)
//   busy_o           batch in progress
//   batch_done_o     one-cycle batch completion pulse
// ---------------------------------------------------------------------------
interface mem_share_rr_arbiter_if #(
  parameter int SHARED_BANK_NUM       = 4,
  parameter int IDX_BITWIDTH          = 2,
  parameter int RQST_ADDR_BITWIDTH    = 2,
  parameter int C2V_MEM_ADDR_BITWIDTH = 10
);
  logic [SHARED_BANK_NUM-1:0]                    rqst_flag_i;
  logic [SHARED_BANK_NUM*RQST_ADDR_BITWIDTH-1:0] rqst_addr_i;
  logic                                          batch_start_i;
  logic [C2V_MEM_ADDR_BITWIDTH-1:0]              c2v_base_addr_i;
  logic [SHARED_BANK_NUM-1:0]                    grant_o;
  logic                                          shared_ren_o;
  logic [RQST_ADDR_BITWIDTH-1:0]                 shared_raddr_o;
  logic                                          wb_en_o;
  logic [IDX_BITWIDTH-1:0]                       wb_idx_o;
  logic [C2V_MEM_ADDR_BITWIDTH-1:0]              wb_waddr_o;
  logic                                          busy_o;
  logic                                          batch_done_o;

  modport slave (
    input  rqst_flag_i, rqst_addr_i, batch_start_i, c2v_base_addr_i,
    output grant_o, shared_ren_o, shared_raddr_o, wb_en_o, wb_idx_o,
           wb_waddr_o, busy_o, batch_done_o
  );

  modport master (
    output rqst_flag_i, rqst_addr_i, batch_start_i, c2v_base_addr_i,
    input  grant_o, shared_ren_o, shared_raddr_o, wb_en_o, wb_idx_o,
           wb_waddr_o, busy_o, batch_done_o
  );
endinterface

// File: rtl/mem_share_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mem_share_rr_arbiter
// Round-robin sequencer for one shared group of column-bank memories / IB-LUTs
// in the layered LDPC decoder. Each batch latches the request flags, column
// addresses and write-back base, serialises the requests onto the single
// shared read port (one grant per cycle) and issues the matching C2V write-back
// strobes MEM_RD_LATENCY cycles after each grant.
// Ports:
//   sys_clk       clock
//   rstn          synchronous active-low reset
//   bus           mem_share_rr_arbiter_if.slave (requests, grants, write-backs)
//   dbg_state_o   current FSM state (IDLE=0, SERVE=1, DRAIN=2, DONE=3)
//   dbg_rr_ptr_o  current round-robin pointer
// Handshake: batch_start_i is a valid strobe and ~busy_o is its ready; a start
// is taken only on a cycle where busy_o is low and is otherwise dropped.
// grant_o, wb_en_o and batch_done_o are single-cycle strobes with no
// backpressure; the consumer must take them on the cycle they are high.
// ---------------------------------------------------------------------------
module mem_share_rr_arbiter #(
  parameter int SHARED_BANK_NUM       = 4,
  parameter int IDX_BITWIDTH          = 2,
  parameter int RQST_ADDR_BITWIDTH    = 2,
  parameter int MEM_RD_LATENCY        = 2,
  parameter int C2V_MEM_ADDR_BITWIDTH = 10
) (
  input  logic                     sys_clk,
  input  logic                     rstn,
  mem_share_rr_arbiter_if.slave    bus,
  output logic [1:0]               dbg_state_o,
  output logic [IDX_BITWIDTH-1:0]  dbg_rr_ptr_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state_q, state_nxt;

  logic [SHARED_BANK_NUM-1:0]                    pending_q;
  logic [SHARED_BANK_NUM*RQST_ADDR_BITWIDTH-1:0] addr_q;
  logic [C2V_MEM_ADDR_BITWIDTH-1:0]              base_q;
  logic [IDX_BITWIDTH-1:0]                       rr_ptr_q;

  // Write-back pipe: stage 0 is loaded on the same edge as the grant, so the
  // registered strobe taken from the last stage lands MEM_RD_LATENCY edges later.
  logic [MEM_RD_LATENCY-1:0]                    wb_vld_q;
  logic [MEM_RD_LATENCY-1:0][IDX_BITWIDTH-1:0]  wb_idx_q;

  logic [SHARED_BANK_NUM-1:0]       grant_q;
  logic                             ren_q;
  logic [RQST_ADDR_BITWIDTH-1:0]    raddr_q;
  logic                             wb_en_q;
  logic [IDX_BITWIDTH-1:0]          wb_idx_out_q;
  logic [C2V_MEM_ADDR_BITWIDTH-1:0] wb_waddr_q;
  logic                             busy_q;
  logic                             done_q;

  logic                       win_found;
  logic [IDX_BITWIDTH-1:0]    win_idx;
  logic [SHARED_BANK_NUM-1:0] win_onehot;
  logic                       pipe_tail_busy;

  // Winner: first pending requester at or after rr_ptr, wrapping around.
  always_comb begin
    logic [IDX_BITWIDTH-1:0] cand;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = 0; off < SHARED_BANK_NUM; off++) begin
      cand = rr_ptr_q + IDX_BITWIDTH'(off);
      if (!win_found && pending_q[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    if (win_found) begin
      win_onehot[win_idx] = 1'b1;
    end
  end

  // Entries that will still be in the pipe after the coming shift. The last
  // stage is leaving on this edge, so it does not hold DRAIN back.
  always_comb begin
    pipe_tail_busy = 1'b0;
    for (int i = 0; i < MEM_RD_LATENCY - 1; i++) begin
      pipe_tail_busy = pipe_tail_busy | wb_vld_q[i];
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.batch_start_i) begin
          state_nxt = (bus.rqst_flag_i != '0) ? ST_SERVE : ST_DONE;
        end
      end
      ST_SERVE: begin
        if ((pending_q & ~win_onehot) == '0) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!pipe_tail_busy) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Batch context, round-robin pointer and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      pending_q    <= '0;
      addr_q       <= '0;
      base_q       <= '0;
      rr_ptr_q     <= '0;
      wb_vld_q     <= '0;
      wb_idx_q     <= '0;
      grant_q      <= '0;
      ren_q        <= 1'b0;
      raddr_q      <= '0;
      wb_en_q      <= 1'b0;
      wb_idx_out_q <= '0;
      wb_waddr_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && bus.batch_start_i) begin
        pending_q <= bus.rqst_flag_i;
        addr_q    <= bus.rqst_addr_i;
        base_q    <= bus.c2v_base_addr_i;
      end

      if (state_q == ST_SERVE) begin
        pending_q <= pending_q & ~win_onehot;
        if (win_found) begin
          rr_ptr_q <= win_idx + IDX_BITWIDTH'(1);
        end
        grant_q <= win_onehot;
        ren_q   <= win_found;
        raddr_q <= addr_q[int'(win_idx)*RQST_ADDR_BITWIDTH +: RQST_ADDR_BITWIDTH];
      end else begin
        grant_q <= '0;
        ren_q   <= 1'b0;
        raddr_q <= '0;
      end

      wb_vld_q[0] <= (state_q == ST_SERVE) && win_found;
      wb_idx_q[0] <= ((state_q == ST_SERVE) && win_found) ? win_idx : '0;
      for (int i = 1; i < MEM_RD_LATENCY; i++) begin
        wb_vld_q[i] <= wb_vld_q[i-1];
        wb_idx_q[i] <= wb_idx_q[i-1];
      end

      wb_en_q <= wb_vld_q[MEM_RD_LATENCY-1];
      if (wb_vld_q[MEM_RD_LATENCY-1]) begin
        wb_idx_out_q <= wb_idx_q[MEM_RD_LATENCY-1];
        wb_waddr_q   <= base_q + C2V_MEM_ADDR_BITWIDTH'(wb_idx_q[MEM_RD_LATENCY-1]);
      end else begin
        wb_idx_out_q <= '0;
        wb_waddr_q   <= '0;
      end

      busy_q <= (state_nxt != ST_IDLE);
      done_q <= (state_q == ST_DONE);
    end
  end

  assign bus.grant_o        = grant_q;
  assign bus.shared_ren_o   = ren_q;
  assign bus.shared_raddr_o = raddr_q;
  assign bus.wb_en_o        = wb_en_q;
  assign bus.wb_idx_o       = wb_idx_out_q;
  assign bus.wb_waddr_o     = wb_waddr_q;
  assign bus.busy_o         = busy_q;
  assign bus.batch_done_o   = done_q;

  assign dbg_state_o  = state_q;
  assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_mem_share_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_share_rr_arbiter
// Drives directed and random batches into mem_share_rr_arbiter. For each batch
// the reference model derives the grant order (set flags taken in ascending
// order starting from the round-robin pointer) and the cycle at which every
// grant, write-back and completion pulse must appear; a monitor pops and
// compares them as the outputs fire.
// ---------------------------------------------------------------------------
module tb_mem_share_rr_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int AW = 2;
  localparam int L  = 2;
  localparam int CW = 10;

  logic sys_clk = 1'b0;
  logic rstn    = 1'b0;
  logic [1:0]    dbg_state;
  logic [IW-1:0] dbg_rr;

  mem_share_rr_arbiter_if #(
    .SHARED_BANK_NUM(N), .IDX_BITWIDTH(IW),
    .RQST_ADDR_BITWIDTH(AW), .C2V_MEM_ADDR_BITWIDTH(CW)
  ) bus ();

  mem_share_rr_arbiter #(
    .SHARED_BANK_NUM(N), .IDX_BITWIDTH(IW), .RQST_ADDR_BITWIDTH(AW),
    .MEM_RD_LATENCY(L), .C2V_MEM_ADDR_BITWIDTH(CW)
  ) dut (
    .sys_clk      (sys_clk),
    .rstn         (rstn),
    .bus          (bus.slave),
    .dbg_state_o  (dbg_state),
    .dbg_rr_ptr_o (dbg_rr)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  int model_ptr = 0;

  // grant entry: {cycle, onehot, raddr}; wb entry: {cycle, idx, waddr}; done: cycle
  logic [21:0] g_exp_q[$];
  logic [27:0] w_exp_q[$];
  logic [15:0] d_exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge sys_clk) begin
    logic [21:0] g_act;
    logic [27:0] w_act;
    logic [15:0] d_act;
    if (mon_en) begin
      checks++;
      if (!$onehot0(bus.grant_o) || (bus.shared_ren_o !== (bus.grant_o != '0))) begin
        errors++;
        $display("FAIL grant_shape cyc=%0d got grant=%b ren=%b want onehot0 with ren=|grant",
                 cyc, bus.grant_o, bus.shared_ren_o);
      end
      if (bus.grant_o != '0) begin
        g_act = {16'(cyc), bus.grant_o, bus.shared_raddr_o};
        checks++;
        if (g_exp_q.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected cyc=%0d got=%h want none", cyc, g_act);
        end else if (g_act !== g_exp_q[0]) begin
          errors++;
          $display("FAIL grant cyc=%0d got=%h want=%h", cyc, g_act, g_exp_q.pop_front());
        end else begin
          void'(g_exp_q.pop_front());
        end
      end
      if (bus.wb_en_o) begin
        w_act = {16'(cyc), bus.wb_idx_o, bus.wb_waddr_o};
        checks++;
        if (w_exp_q.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected cyc=%0d got=%h want none", cyc, w_act);
        end else if (w_act !== w_exp_q[0]) begin
          errors++;
          $display("FAIL wb cyc=%0d got=%h want=%h", cyc, w_act, w_exp_q.pop_front());
        end else begin
          void'(w_exp_q.pop_front());
        end
      end
      if (bus.batch_done_o) begin
        d_act = 16'(cyc);
        checks++;
        if (d_exp_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected cyc=%0d want none", cyc);
        end else if (d_act !== d_exp_q[0]) begin
          errors++;
          $display("FAIL done cyc=%0d got=%0d want=%0d", cyc, d_act, d_exp_q.pop_front());
        end else begin
          void'(d_exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_batch(input logic [N-1:0] flags, input logic [N*AW-1:0] addr,
                           input logic [CW-1:0] base, input bit ign_start, input bit rst_mid);
    int order[$];
    int e0, k, busy_end;
    logic [CW-1:0] wa;
    logic [N-1:0]  oh;
    for (int off = 0; off < N; off++) begin
      int idx = (model_ptr + off) % N;
      if (flags[idx]) order.push_back(idx);
    end
    k = order.size();
    @(negedge sys_clk);
    e0 = cyc + 1;
    busy_end = (k == 0) ? e0 : e0 + k + L;
    for (int i = 0; i < k; i++) begin
      oh = '0;
      oh[order[i]] = 1'b1;
      g_exp_q.push_back({16'(e0 + i + 1), oh, addr[order[i]*AW +: AW]});
      wa = base + CW'(order[i]);
      w_exp_q.push_back({16'(e0 + i + 1 + L), IW'(order[i]), wa});
    end
    d_exp_q.push_back(16'(busy_end + 1));
    if (!rst_mid && k > 0) model_ptr = (order[k-1] + 1) % N;

    bus.rqst_flag_i     = flags;
    bus.rqst_addr_i     = addr;
    bus.c2v_base_addr_i = base;
    bus.batch_start_i   = 1'b1;
    @(negedge sys_clk);
    bus.batch_start_i = 1'b0;

    for (int n = 0; n < busy_end - e0 + 4; n++) begin
      check("busy", 32'(bus.busy_o), 32'(cyc >= e0 && cyc <= busy_end));
      if (rst_mid && cyc == e0 + 2) begin
        #2;
        rstn = 1'b0;
        g_exp_q.delete();
        w_exp_q.delete();
        d_exp_q.delete();
        model_ptr = 0;
        @(negedge sys_clk);
        check("rst_grant", 32'(bus.grant_o), 32'd0);
        check("rst_wb_en", 32'(bus.wb_en_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_rr_ptr", 32'(dbg_rr), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rstn = 1'b1;
        repeat (6) @(negedge sys_clk);
        break;
      end
      // Inputs wander while busy; a mid-batch start must be ignored.
      bus.rqst_flag_i     = N'($urandom_range(0, 15));
      bus.rqst_addr_i     = (N*AW)'($urandom);
      bus.c2v_base_addr_i = CW'($urandom);
      if (ign_start && cyc == e0 + 1) begin
        bus.rqst_flag_i   = '1;
        bus.batch_start_i = 1'b1;
      end else begin
        bus.batch_start_i = 1'b0;
      end
      @(negedge sys_clk);
    end
    bus.batch_start_i = 1'b0;
    #1;
    check("grants_left", 32'(g_exp_q.size()), 32'd0);
    check("wbs_left", 32'(w_exp_q.size()), 32'd0);
    check("done_left", 32'(d_exp_q.size()), 32'd0);
    check("rr_ptr", 32'(dbg_rr), 32'(model_ptr));
    g_exp_q.delete();
    w_exp_q.delete();
    d_exp_q.delete();
  endtask

  initial begin
    bus.rqst_flag_i     = '0;
    bus.rqst_addr_i     = '0;
    bus.batch_start_i   = 1'b0;
    bus.c2v_base_addr_i = '0;
    rstn = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("reset_grant", 32'(bus.grant_o), 32'd0);
    check("reset_ren", 32'(bus.shared_ren_o), 32'd0);
    check("reset_wb", 32'({bus.wb_en_o, bus.wb_idx_o, bus.wb_waddr_o}), 32'd0);
    check("reset_busy_done", 32'({bus.busy_o, bus.batch_done_o}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    check("reset_rr_ptr", 32'(dbg_rr), 32'd0);
    rstn   = 1'b1;
    mon_en = 1'b1;

    // all four requesters, addr {3,2,1,0}
    run_batch(4'b1111, 8'hE4, 10'd100, 1'b0, 1'b0);
    // fairness: pointer left at 2, then 0 is served before 1
    run_batch(4'b0010, 8'h1B, 10'd5, 1'b0, 1'b0);
    run_batch(4'b0011, 8'h36, 10'd7, 1'b0, 1'b0);
    // empty batch
    run_batch(4'b0000, 8'h00, 10'd9, 1'b0, 1'b0);
    // write-back address wraps
    run_batch(4'b0100, 8'hFF, 10'h3FF, 1'b0, 1'b0);
    // start pulse while serving is ignored
    run_batch(4'b1010, 8'h9C, 10'd200, 1'b1, 1'b0);
    run_batch(4'b1111, 8'h4E, 10'd300, 1'b1, 1'b0);
    // reset after the second grant
    run_batch(4'b1111, 8'hE4, 10'd400, 1'b0, 1'b1);
    run_batch(4'b1001, 8'h81, 10'd50, 1'b0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      run_batch(N'($urandom_range(0, 15)), (N*AW)'($urandom), CW'($urandom), 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge sys_clk);
    end

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got no end of test want finish", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
